// File: rtl/sop_sweep_ctrl_pkg.sv
// Shared definitions for the NOR-SOP self-test sweep controller.
//   state_t    : controller FSM state encoding (2 bits)
//   GOLDEN_TT  : expected truth table of f = b'd' + b'c' + a'c'd'
//   ABCD_*     : bit positions of a, b, c, d inside the abcd vector
//   LAST_VEC   : final minterm of a sweep
package sop_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] GOLDEN_TT = 16'h0717;

  localparam int ABCD_A = 3;
  localparam int ABCD_B = 2;
  localparam int ABCD_C = 1;
  localparam int ABCD_D = 0;

  localparam logic [3:0] LAST_VEC = 4'd15;

endpackage

// File: rtl/sop_golden.sv
// Combinational golden model of the NOR-only SOP unit.
//   abcd : input vector, abcd[3]=a .. abcd[0]=d
//   g    : expected output (~b&~d)|(~b&~c)|(~a&~c&~d)
module sop_golden
  import sop_sweep_ctrl_pkg::*;
(
  input  logic [3:0] abcd,
  output logic       g
);

  logic a, b, c, d;

  assign a = abcd[ABCD_A];
  assign b = abcd[ABCD_B];
  assign c = abcd[ABCD_C];
  assign d = abcd[ABCD_D];

  assign g = (~b & ~d) | (~b & ~c) | (~a & ~c & ~d);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Self-test sequencer for the NOR-only SOP unit. On start it walks abcd
// through 0..15, waits SETTLE cycles per vector, samples f_dut and compares
// it with the golden function, recording truth table and mismatch data.
//   clk, rst_n      : clock, synchronous active-low reset
//   start, abort    : sweep request (idle only) / cancel (busy only)
//   f_dut           : output of the unit under test
//   abcd            : vector driven to the unit
//   busy, done      : sweeping / one-cycle completion pulse
//   pass            : last completed sweep had no mismatches
//   mismatch_cnt    : failing minterm count, 0..16
//   first_fail(_vld): lowest failing minterm and its valid flag
//   tt_dut          : captured truth table, bit m = f_dut at abcd=m
module sop_sweep_ctrl
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_dut,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail,
  output logic        first_fail_vld,
  output logic [15:0] tt_dut
);

  // Last settle count before sampling; unused when SETTLE=0 because the
  // SETTLE state is skipped entirely.
  localparam logic [3:0] SETTLE_LAST  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam state_t     ST_VEC_START = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        pass_q, pass_d;
  logic [4:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic        first_fail_vld_q, first_fail_vld_d;
  logic [15:0] tt_dut_q, tt_dut_d;
  logic        g_exp;

  sop_golden u_golden (
    .abcd (abcd_q),
    .g    (g_exp)
  );

  always_comb begin
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    abcd_d           = abcd_q;
    pass_d           = pass_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
    tt_dut_d         = tt_dut_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_VEC_START;
          settle_cnt_d     = 4'd0;
          abcd_d           = 4'd0;
          pass_d           = 1'b0;
          mismatch_cnt_d   = 5'd0;
          first_fail_d     = 4'd0;
          first_fail_vld_d = 1'b0;
          tt_dut_d         = 16'h0000;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          abcd_d  = 4'd0;
          pass_d  = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          abcd_d  = 4'd0;
          pass_d  = 1'b0;
        end else begin
          tt_dut_d[abcd_q] = f_dut;
          if (f_dut != g_exp) begin
            mismatch_cnt_d = mismatch_cnt_q + 5'd1;
            if (!first_fail_vld_q) begin
              first_fail_d     = abcd_q;
              first_fail_vld_d = 1'b1;
            end
          end
          if (abcd_q == LAST_VEC) begin
            // Verdict is registered here so it is already valid in DONE.
            state_d = ST_DONE;
            pass_d  = (mismatch_cnt_d == 5'd0);
          end else begin
            state_d      = ST_VEC_START;
            abcd_d       = abcd_q + 4'd1;
            settle_cnt_d = 4'd0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      settle_cnt_q     <= 4'd0;
      abcd_q           <= 4'd0;
      pass_q           <= 1'b0;
      mismatch_cnt_q   <= 5'd0;
      first_fail_q     <= 4'd0;
      first_fail_vld_q <= 1'b0;
      tt_dut_q         <= 16'h0000;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      abcd_q           <= abcd_d;
      pass_q           <= pass_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
      tt_dut_q         <= tt_dut_d;
    end
  end

  assign abcd           = abcd_q;
  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;
  assign tt_dut         = tt_dut_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Bench for sop_sweep_ctrl: a SETTLE=2 and a SETTLE=0 instance, each fed by
// a golden function XOR a per-minterm fault mask. Expected results are
// derived at truth-table level from the mask.
module tb_sop_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start2, abort2, f2, busy2, done2, pass2, vld2;
  logic [3:0]  abcd2, ff2;
  logic [4:0]  mm2;
  logic [15:0] tt2;

  logic        start0, abort0, f0, busy0, done0, pass0, vld0;
  logic [3:0]  abcd0, ff0;
  logic [4:0]  mm0;
  logic [15:0] tt0;

  logic [15:0] mask2 = 16'h0000;
  logic [15:0] mask0 = 16'h0000;
  logic [15:0] gold_tt;
  logic        use0 = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic gold_fn(input logic [3:0] m);
    logic a, b, c, d;
    a = m[3]; b = m[2]; c = m[1]; d = m[0];
    return (!b && !d) || (!b && !c) || (!a && !c && !d);
  endfunction

  assign f2 = gold_fn(abcd2) ^ mask2[abcd2];
  assign f0 = gold_fn(abcd0) ^ mask0[abcd0];

  sop_sweep_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .f_dut(f2),
    .abcd(abcd2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_cnt(mm2), .first_fail(ff2), .first_fail_vld(vld2), .tt_dut(tt2)
  );

  sop_sweep_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_dut(f0),
    .abcd(abcd0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_cnt(mm0), .first_fail(ff0), .first_fail_vld(vld0), .tt_dut(tt0)
  );

  logic        s_busy, s_done, s_pass, s_vld;
  logic [3:0]  s_abcd, s_ff;
  logic [4:0]  s_mm;
  logic [15:0] s_tt;
  assign s_busy = use0 ? busy0 : busy2;
  assign s_done = use0 ? done0 : done2;
  assign s_pass = use0 ? pass0 : pass2;
  assign s_vld  = use0 ? vld0  : vld2;
  assign s_abcd = use0 ? abcd0 : abcd2;
  assign s_ff   = use0 ? ff0   : ff2;
  assign s_mm   = use0 ? mm0   : mm2;
  assign s_tt   = use0 ? tt0   : tt2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic v);
    if (use0) start0 = v; else start2 = v;
  endtask

  task automatic drive_abort(input logic v);
    if (use0) abort0 = v; else abort2 = v;
  endtask

  // Runs one sweep on the selected instance. abort_at / stray_at give the
  // busy cycle (1 = first cycle after the start edge) for an abort or an
  // extra start pulse; 0 disables them.
  task automatic run_sweep(input logic sel, input logic [15:0] mask,
                           input int abort_at, input int stray_at,
                           input string name);
    int          per, total, n;
    logic [15:0] exp_tt;
    logic [4:0]  exp_mm;
    logic [3:0]  exp_ff;
    logic        exp_vld, exp_pass, seq_ok, seen_done;
    use0 = sel;
    if (sel) mask0 = mask; else mask2 = mask;
    per      = sel ? 1 : 3;
    total    = 1 + 16 * per;
    exp_tt   = gold_tt ^ mask;
    exp_mm   = 5'($countones(mask));
    exp_vld  = (mask != 16'h0000);
    exp_pass = (mask == 16'h0000);
    exp_ff   = 4'd0;
    for (int m = 15; m >= 0; m--) if (mask[m]) exp_ff = 4'(m);

    drive_start(1'b1);
    tick;
    drive_start(1'b0);
    n = 1;
    seq_ok = 1'b1;
    checks++;
    if (s_busy !== 1'b1 || s_abcd !== 4'd0) begin
      errors++;
      $display("FAIL %s start_accept busy=%b abcd=%h exp busy=1 abcd=0", name, s_busy, s_abcd);
    end

    while (n < total) begin
      if (s_busy !== 1'b1 || s_done !== 1'b0 || s_abcd !== 4'((n - 1) / per)) begin
        if (seq_ok)
          $display("FAIL %s sequence cycle=%0d busy=%b done=%b abcd=%h exp 1/0/%h",
                   name, n, s_busy, s_done, s_abcd, 4'((n - 1) / per));
        seq_ok = 1'b0;
      end
      if (n == abort_at) begin
        drive_abort(1'b1);
        tick;
        drive_abort(1'b0);
        checks++;
        if (s_busy !== 1'b0 || s_abcd !== 4'd0 || s_pass !== 1'b0 || s_done !== 1'b0) begin
          errors++;
          $display("FAIL %s abort busy=%b abcd=%h pass=%b done=%b exp 0/0/0/0",
                   name, s_busy, s_abcd, s_pass, s_done);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
          tick;
          if (s_done !== 1'b0 || s_busy !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
          errors++;
          $display("FAIL %s abort_quiet activity after abort got 1 exp 0", name);
        end
        return;
      end
      if (n == stray_at) drive_start(1'b1);
      tick;
      drive_start(1'b0);
      n++;
    end

    checks++;
    if (!seq_ok) errors++;
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle cycle=%0d done=%b busy=%b exp 1/0", name, n, s_done, s_busy);
    end
    checks++;
    if (s_tt !== exp_tt) begin
      errors++;
      $display("FAIL %s tt_dut got %h exp %h", name, s_tt, exp_tt);
    end
    checks++;
    if (s_mm !== exp_mm) begin
      errors++;
      $display("FAIL %s mismatch_cnt got %0d exp %0d", name, s_mm, exp_mm);
    end
    checks++;
    if (s_vld !== exp_vld || s_ff !== exp_ff) begin
      errors++;
      $display("FAIL %s first_fail got vld=%b ff=%0d exp vld=%b ff=%0d", name, s_vld, s_ff, exp_vld, exp_ff);
    end
    checks++;
    if (s_pass !== exp_pass) begin
      errors++;
      $display("FAIL %s pass got %b exp %b", name, s_pass, exp_pass);
    end

    tick;
    checks++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_tt !== exp_tt || s_pass !== exp_pass || s_mm !== exp_mm) begin
      errors++;
      $display("FAIL %s hold done=%b busy=%b tt=%h pass=%b mm=%0d exp 0/0/%h/%b/%0d",
               name, s_done, s_busy, s_tt, s_pass, s_mm, exp_tt, exp_pass, exp_mm);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({abcd2, busy2, done2, pass2, mm2, ff2, vld2, tt2} !== 32'h0 ||
        {abcd0, busy0, done0, pass0, mm0, ff0, vld0, tt0} !== 32'h0) begin
      errors++;
      $display("FAIL %s reset_vals s2=%h s0=%h exp 0/0",
               name, {abcd2, busy2, done2, pass2, mm2, ff2, vld2, tt2},
               {abcd0, busy0, done0, pass0, mm0, ff0, vld0, tt0});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    repeat (3) tick;
    check_reset_vals("reset_held");
    rst_n = 1'b1;
    repeat (2) tick;
    check_reset_vals("reset_released");
  endtask

  task automatic test_spec_cases;
    run_sweep(1'b0, 16'h0000, 0, 0, "correct");
    run_sweep(1'b0, gold_tt, 0, 0, "stuck0");
    run_sweep(1'b0, ~gold_tt, 0, 0, "stuck1");
    run_sweep(1'b0, 16'h8000, 0, 0, "inv15");
  endtask

  task automatic test_abort;
    run_sweep(1'b0, 16'($urandom), 10, 0, "abort");
    run_sweep(1'b0, 16'($urandom), 0, 0, "after_abort");
  endtask

  task automatic test_stray_start;
    run_sweep(1'b0, 16'($urandom), 0, 20, "stray_start");
  endtask

  task automatic test_reset_mid;
    use0 = 1'b0;
    mask2 = ~gold_tt;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    repeat (20) tick;
    rst_n = 1'b0;
    tick;
    check_reset_vals("reset_mid");
    rst_n = 1'b1;
    tick;
    check_reset_vals("reset_mid_idle");
  endtask

  task automatic test_settle0;
    run_sweep(1'b1, 16'h0000, 0, 0, "settle0_correct");
    run_sweep(1'b1, 16'($urandom), 0, 0, "settle0_rand");
    run_sweep(1'b1, 16'($urandom), 5, 0, "settle0_abort");
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++)
      run_sweep(1'($urandom), 16'($urandom), 0, 0, "random");
  endtask

  task automatic test_back_to_back;
    run_sweep(1'b0, 16'hFFFF, 0, 0, "b2b_first");
    run_sweep(1'b0, 16'h0001, 0, 0, "b2b_second");
  endtask

  initial begin
    for (int m = 0; m < 16; m++) gold_tt[m] = gold_fn(4'(m));
    test_reset;
    test_spec_cases;
    test_abort;
    test_stray_start;
    test_reset_mid;
    test_settle0;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
